// File: rtl/rx_drain_ctrl_if.sv
// Engine-facing and host-facing signals of the receive drain controller.
// slave = the controller, master = whatever drives the engine and host side.
interface rx_drain_ctrl_if #(
  parameter int AW = 3
);
  logic          rx_rdy;
  logic [7:0]    rx_data;
  logic          p_err;
  logic          frm_err;
  logic          ov_err;
  logic          rd_strb;
  logic          host_rd;
  logic [7:0]    host_data;
  logic          host_perr;
  logic          host_ferr;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          irq_en;
  logic          clr_err;
  logic          ov_stky;
  logic          tout_stky;
  logic          irq;

  modport slave (
    input  rx_rdy, rx_data, p_err, frm_err, ov_err, host_rd, irq_en, clr_err,
    output rd_strb, host_data, host_perr, host_ferr, empty, full, count,
           ov_stky, tout_stky, irq
  );

  modport master (
    output rx_rdy, rx_data, p_err, frm_err, ov_err, host_rd, irq_en, clr_err,
    input  rd_strb, host_data, host_perr, host_ferr, empty, full, count,
           ov_stky, tout_stky, irq
  );
endinterface

// File: rtl/rx_drain_ctrl.sv
// Receive drain controller: captures engine bytes and error tags into a FIFO,
// acknowledges the engine with rd_strb, and serves the host with FWFT reads.
//
// state    | meaning
// IDLE     | waiting for Rx_rdy; captures the byte when the FIFO has room
// STROBE   | rd_strb asserted for this single cycle
// WAIT_LOW | waiting for the engine to drop Rx_rdy before re-arming
module rx_drain_ctrl #(
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int THRESH = 4,
  parameter int TOUT   = 1024
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  rx_drain_ctrl_if.slave bus
);

  localparam int              TW       = (TOUT > 1) ? $clog2(TOUT) : 1;
  localparam logic [AW:0]     DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]     THRESH_C = (AW+1)'(THRESH);
  localparam logic [TW-1:0]   TLIM     = TW'(TOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STROBE   = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [9:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [TW-1:0]   r_tcnt;
  logic            r_ov_stky;
  logic            r_tout_stky;
  logic            r_irq;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic            w_idle;
  logic            w_tout_set;
  logic [9:0]      w_head;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_pop   = bus.host_rd & ~w_empty;

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.rx_rdy && !w_full) begin
          w_push      = 1'b1;
          w_state_nxt = STROBE;
        end
      end
      STROBE:   w_state_nxt = WAIT_LOW;
      WAIT_LOW: if (!bus.rx_rdy) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Storage carries no reset; the head is masked while empty instead.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.frm_err, bus.p_err, bus.rx_data};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Counter saturates at TLIM; every idle edge spent there re-asserts the flag.
  assign w_idle     = ~w_push & ~w_pop & ~w_empty;
  assign w_tout_set = w_idle & (r_tcnt == TLIM);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tcnt <= '0;
    end else if (!w_idle) begin
      r_tcnt <= '0;
    end else if (r_tcnt != TLIM) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ov_stky   <= 1'b0;
      r_tout_stky <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (bus.ov_err)       r_ov_stky <= 1'b1;
      else if (bus.clr_err) r_ov_stky <= 1'b0;

      if (w_tout_set)                r_tout_stky <= 1'b1;
      else if (bus.clr_err || w_pop) r_tout_stky <= 1'b0;

      r_irq <= bus.irq_en & ((r_count >= THRESH_C) | r_ov_stky | r_tout_stky);
    end
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign bus.host_data = w_empty ? 8'h00 : w_head[7:0];
  assign bus.host_perr = ~w_empty & w_head[8];
  assign bus.host_ferr = ~w_empty & w_head[9];
  assign bus.rd_strb   = (r_state == STROBE);
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.count     = r_count;
  assign bus.ov_stky   = r_ov_stky;
  assign bus.tout_stky = r_tout_stky;
  assign bus.irq       = r_irq;

endmodule

// File: tb/tb_rx_drain_ctrl.sv
// Bench for rx_drain_ctrl: directed scenarios plus random traffic, compared
// each cycle against a queue-based model of the capture/read/flag rules.
module tb_rx_drain_ctrl;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;
  localparam int THRESH = 4;
  localparam int TOUT   = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rx_drain_ctrl_if #(.AW(AW)) bus ();

  rx_drain_ctrl #(.DEPTH(DEPTH), .AW(AW), .THRESH(THRESH), .TOUT(TOUT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [9:0] q[$];
  bit  m_strb, m_can, m_just, m_ov, m_to, m_irq;
  int  m_idle;

  task automatic model_reset();
    q.delete();
    m_strb = 0; m_can = 1; m_just = 0;
    m_ov = 0; m_to = 0; m_irq = 0; m_idle = 0;
  endtask

  function automatic logic [19:0] model_vec();
    logic [9:0] h;
    h = (q.size() > 0) ? q[0] : 10'd0;
    return {m_strb, q.size() == 0, q.size() == DEPTH, 4'(q.size()),
            h[7:0], h[8], h[9], m_ov, m_to, m_irq};
  endfunction

  function automatic logic [19:0] dut_vec();
    return {bus.rd_strb, bus.empty, bus.full, bus.count, bus.host_data,
            bus.host_perr, bus.host_ferr, bus.ov_stky, bus.tout_stky, bus.irq};
  endfunction

  // Advance one clock: apply the rules to the pre-edge inputs and state.
  task automatic tick();
    bit full, empty, push, pop, idle, tset;
    int sz;
    @(posedge clk);
    sz    = q.size();
    full  = (sz == DEPTH);
    empty = (sz == 0);
    push  = m_can && bus.rx_rdy && !full;
    pop   = bus.host_rd && !empty;
    idle  = !push && !pop && !empty;
    if (!idle) m_idle = 0;
    else if (m_idle < TOUT) m_idle++;
    tset  = idle && (m_idle >= TOUT);
    m_irq = bus.irq_en && ((sz >= THRESH) || m_ov || m_to);
    m_ov  = bus.ov_err ? 1'b1 : (bus.clr_err ? 1'b0 : m_ov);
    m_to  = tset ? 1'b1 : ((bus.clr_err || pop) ? 1'b0 : m_to);
    if (!m_can && !m_just && !bus.rx_rdy) m_can = 1;
    if (push) m_can = 0;
    m_just = push;
    m_strb = push;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back({bus.frm_err, bus.p_err, bus.rx_data});
    #2;
  endtask

  task automatic quiet_inputs();
    bus.rx_rdy = 0; bus.rx_data = 8'h00; bus.p_err = 0; bus.frm_err = 0;
    bus.ov_err = 0; bus.host_rd = 0; bus.clr_err = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #3;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    bus.rx_rdy = 0;
    bus.host_rd = 1;
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) tick();
    bus.host_rd = 0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    quiet_inputs();
    bus.irq_en = 0;
    rst_n = 1'b0;
    model_reset();
    #12;
    checks++;
    if (dut_vec() !== 20'h40000) begin
      errors++; $display("FAIL reset_state dut=%h exp=%h", dut_vec(), 20'h40000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL reset_idle dut=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_single_byte();
    int strb_cycles;
    strb_cycles = 0;
    bus.rx_data = 8'h5A; bus.rx_rdy = 1;
    tick();
    bus.rx_rdy = 0;
    strb_cycles += bus.rd_strb;
    checks++;
    if (bus.count !== 4'd1 || bus.host_data !== 8'h5A) begin
      errors++; $display("FAIL single_capture count=%0d data=%h exp 1/5a", bus.count, bus.host_data);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      strb_cycles += bus.rd_strb;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL single_cyc%0d dut=%h exp=%h", i, dut_vec(), model_vec());
      end
    end
    checks++;
    if (strb_cycles != 1) begin
      errors++; $display("FAIL single_strb_len got=%0d exp=1", strb_cycles);
    end
    bus.host_rd = 1;
    tick();
    bus.host_rd = 0;
    checks++;
    if (bus.empty !== 1'b1 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL single_pop dut=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_fill_full();
    bus.irq_en = 1;
    for (int k = 1; k <= DEPTH; k++) begin
      bus.rx_data = 8'(k); bus.rx_rdy = 1;
      for (int c = 0; c < 3; c++) begin
        tick();
        bus.rx_rdy = 0;
        checks++;
        if (dut_vec() !== model_vec()) begin
          errors++; $display("FAIL fill k=%0d c=%0d dut=%h exp=%h", k, c, dut_vec(), model_vec());
        end
      end
    end
    bus.rx_data = 8'h09; bus.rx_rdy = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (bus.full !== 1'b1 || bus.rd_strb !== 1'b0 || bus.irq !== 1'b1) begin
        errors++; $display("FAIL full_hold full=%b strb=%b irq=%b exp 1/0/1", bus.full, bus.rd_strb, bus.irq);
      end
    end
    bus.host_rd = 1;
    tick();
    bus.host_rd = 0;
    tick();
    checks++;
    if (bus.rd_strb !== 1'b1 || bus.count !== 4'd8 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL ninth_capture dut=%h exp=%h", dut_vec(), model_vec());
    end
    bus.rx_rdy = 0;
    for (int k = 2; k <= 9; k++) begin
      checks++;
      if (bus.host_data !== 8'(k)) begin
        errors++; $display("FAIL fill_order got=%h exp=%h", bus.host_data, 8'(k));
      end
      bus.host_rd = 1;
      tick();
      bus.host_rd = 0;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL fill_read k=%0d dut=%h exp=%h", k, dut_vec(), model_vec());
      end
    end
    tick();
  endtask

  task automatic test_error_tags();
    logic [7:0] d [2];
    d[0] = 8'h33; d[1] = 8'h44;
    for (int k = 0; k < 2; k++) begin
      bus.rx_data = d[k]; bus.p_err = (k == 0); bus.frm_err = (k == 1); bus.rx_rdy = 1;
      tick();
      bus.rx_rdy = 0; bus.p_err = 0; bus.frm_err = 0;
      tick();
      tick();
    end
    checks++;
    if ({bus.host_data, bus.host_perr, bus.host_ferr} !== {8'h33, 1'b1, 1'b0}) begin
      errors++; $display("FAIL tag_first got=%h/%b/%b exp=33/1/0", bus.host_data, bus.host_perr, bus.host_ferr);
    end
    bus.host_rd = 1;
    tick();
    bus.host_rd = 0;
    checks++;
    if ({bus.host_data, bus.host_perr, bus.host_ferr} !== {8'h44, 1'b0, 1'b1}) begin
      errors++; $display("FAIL tag_second got=%h/%b/%b exp=44/0/1", bus.host_data, bus.host_perr, bus.host_ferr);
    end
    drain();
  endtask

  task automatic test_push_pop();
    for (int k = 0; k < 3; k++) begin
      bus.rx_data = 8'($urandom); bus.rx_rdy = 1;
      tick();
      bus.rx_rdy = 0;
      tick();
      tick();
    end
    bus.rx_data = 8'hC3; bus.rx_rdy = 1; bus.host_rd = 1;
    tick();
    bus.rx_rdy = 0; bus.host_rd = 0;
    checks++;
    if (bus.count !== 4'd3 || bus.rd_strb !== 1'b1 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL pushpop_same count=%0d dut=%h exp=%h", bus.count, dut_vec(), model_vec());
    end
    for (int i = 0; i < 80; i++) begin
      if (bus.rx_rdy && bus.rd_strb) bus.rx_rdy = 0;
      else if (!bus.rx_rdy) begin
        bus.rx_rdy = ($urandom_range(0, 2) != 0);
        bus.rx_data = 8'($urandom);
      end
      bus.host_rd = ($urandom_range(0, 2) != 0);
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL wrap i=%0d dut=%h exp=%h", i, dut_vec(), model_vec());
      end
    end
    drain();
  endtask

  task automatic test_timeout();
    bus.irq_en = 1;
    bus.rx_data = 8'hA1; bus.rx_rdy = 1;
    tick();
    bus.rx_rdy = 0;
    for (int i = 1; i <= TOUT + 2; i++) begin
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL tout_run i=%0d dut=%h exp=%h", i, dut_vec(), model_vec());
      end
    end
    checks++;
    if (bus.tout_stky !== 1'b1 || bus.irq !== 1'b1) begin
      errors++; $display("FAIL tout_set tout=%b irq=%b exp 1/1", bus.tout_stky, bus.irq);
    end
    bus.host_rd = 1;
    tick();
    bus.host_rd = 0;
    checks++;
    if (bus.tout_stky !== 1'b0 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL tout_pop_clr tout=%b exp=0", bus.tout_stky);
    end
    tick();
    bus.rx_data = 8'hB2; bus.rx_rdy = 1;
    tick();
    bus.rx_rdy = 0;
    for (int i = 1; i <= TOUT; i++) begin
      bus.clr_err = (i == TOUT);
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL tout_clr_run i=%0d dut=%h exp=%h", i, dut_vec(), model_vec());
      end
    end
    bus.clr_err = 0;
    checks++;
    if (bus.tout_stky !== 1'b1) begin
      errors++; $display("FAIL tout_set_wins got=%b exp=1", bus.tout_stky);
    end
    bus.host_rd = 1;
    tick();
    bus.host_rd = 0;
    checks++;
    if (bus.tout_stky !== 1'b0 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL tout_final tout=%b empty=%b exp 0/1", bus.tout_stky, bus.empty);
    end
    tick();
    tick();
  endtask

  task automatic test_ov_and_reset();
    bus.irq_en = 1;
    bus.ov_err = 1;
    tick();
    bus.ov_err = 0;
    checks++;
    if (bus.ov_stky !== 1'b1) begin
      errors++; $display("FAIL ov_set got=%b exp=1", bus.ov_stky);
    end
    tick();
    checks++;
    if (bus.irq !== 1'b1 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL ov_irq irq=%b dut=%h exp=%h", bus.irq, dut_vec(), model_vec());
    end
    bus.ov_err = 1; bus.clr_err = 1;
    tick();
    bus.ov_err = 0;
    checks++;
    if (bus.ov_stky !== 1'b1) begin
      errors++; $display("FAIL ov_set_wins got=%b exp=1", bus.ov_stky);
    end
    tick();
    bus.clr_err = 0;
    checks++;
    if (bus.ov_stky !== 1'b0 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL ov_clr dut=%h exp=%h", dut_vec(), model_vec());
    end
    tick();
    bus.rx_data = 8'h77; bus.rx_rdy = 1;
    tick();
    checks++;
    if (bus.rd_strb !== 1'b1 || bus.count !== 4'd1) begin
      errors++; $display("FAIL pre_reset strb=%b count=%0d exp 1/1", bus.rd_strb, bus.count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rd_strb !== 1'b0 || bus.count !== 4'd0 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL async_reset strb=%b count=%0d empty=%b exp 0/0/1", bus.rd_strb, bus.count, bus.empty);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.rx_rdy = 0;
    checks++;
    if (bus.count !== 4'd1 || bus.host_data !== 8'h77 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL recapture dut=%h exp=%h", dut_vec(), model_vec());
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) bus.rx_rdy = ~bus.rx_rdy;
      bus.rx_data = 8'($urandom);
      bus.p_err   = ($urandom_range(0, 3) == 0);
      bus.frm_err = ($urandom_range(0, 3) == 0);
      bus.ov_err  = ($urandom_range(0, 40) == 0);
      bus.clr_err = ($urandom_range(0, 25) == 0);
      bus.host_rd = (i % 200 < 100) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 50) == 0) bus.irq_en = ~bus.irq_en;
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL random i=%0d dut=%h exp=%h", i, dut_vec(), model_vec());
      end
    end
    quiet_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    test_reset();
    test_single_byte();
    test_fill_full();
    test_error_tags();
    test_push_pop();
    test_timeout();
    test_ov_and_reset();
    test_random();
    apply_reset();
    tick();
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL final_reset dut=%h exp=%h", dut_vec(), model_vec());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
